// File: rtl/dl_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dl_mem_arbiter_if
//  Description : Signal bundle between the download/memory arbiter and its
//                environment. It carries the ROM download byte stream, the
//                core read port, the shared memory command port and the
//                core reset / overrun status outputs.
//                The master modport is the arbiter's view. The slave modport
//                is the view of whatever drives the loader, the core and the
//                memory controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dl_mem_arbiter_if;

    // ROM download byte stream (no backpressure)
    logic        dl_active;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;

    // Core read port (level request, one-cycle ack)
    logic        core_rd_req;
    logic [23:0] core_rd_addr;
    logic [15:0] core_rd_data;
    logic        core_rd_ack;

    // Shared memory command port (level request, one-cycle ack)
    logic        mem_req;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_be;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    // Status
    logic        core_reset;
    logic        dl_overrun;

    modport master (
        input  dl_active,
        input  dl_wr,
        input  dl_addr,
        input  dl_data,
        input  core_rd_req,
        input  core_rd_addr,
        output core_rd_data,
        output core_rd_ack,
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_be,
        input  mem_ack,
        input  mem_rdata,
        output core_reset,
        output dl_overrun
    );

    modport slave (
        output dl_active,
        output dl_wr,
        output dl_addr,
        output dl_data,
        output core_rd_req,
        output core_rd_addr,
        input  core_rd_data,
        input  core_rd_ack,
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_be,
        output mem_ack,
        output mem_rdata,
        input  core_reset,
        input  dl_overrun
    );

endinterface
`default_nettype wire

// File: rtl/dl_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dl_mem_arbiter
//  Description : Shares one 16-bit memory port between a ROM download
//                stream (byte writes, buffered in a 4-entry FIFO) and a game
//                core read port. A three-state FSM (IDLE / DL_BUSY /
//                CORE_BUSY) arbitrates only in IDLE. The loader normally
//                wins. A starvation counter forces a core grant after eight
//                loader grants made while the core was waiting.
//  Options     : `define DL_CORE_HOLD_EN  - holds the core in reset during a
//                download and for 16 cycles after it ends. The core cannot
//                be granted while it is held. Without the macro, core_reset
//                is just a registered copy of reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module dl_mem_arbiter (
    input  wire              clk_sys,
    input  wire              reset,
    dl_mem_arbiter_if.master bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_fifo_full   = 3'd4;  // entry count when full
    localparam logic [3:0] c_starve_max  = 4'd8;  // loader grants before core wins
`ifdef DL_CORE_HOLD_EN
    localparam logic [4:0] c_hold_cycles = 5'd16; // core reset tail after download
`endif

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DL_BUSY   = 2'd1,
        S_CORE_BUSY = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t      state_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [23:0] mem_addr_q;
    logic [15:0] mem_wdata_q;
    logic [1:0]  mem_be_q;
    logic        core_rd_ack_q;
    logic [15:0] core_rd_data_q;
    logic [3:0]  starve_q;
    logic        dl_overrun_q;
    logic        core_reset_q;

    // Download FIFO: each entry is {byte address, byte}
    logic [32:0] fifo_q [0:3];
    logic [1:0]  wr_ptr_q;
    logic [1:0]  rd_ptr_q;
    logic [2:0]  fifo_cnt_q;
    logic [2:0]  fifo_cnt_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic        w_fifo_empty;
    logic        w_fifo_full;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic [24:0] w_head_addr;
    logic [7:0]  w_head_data;
    logic        w_core_block;
    logic        w_core_ok;
    logic        w_core_first;
    logic        w_grant_dl;
    logic        w_grant_core;

    assign w_fifo_empty = (fifo_cnt_q == 3'd0);
    assign w_fifo_full  = (fifo_cnt_q == c_fifo_full);

    // The head entry stays in the FIFO while its write is in flight. It is
    // popped only when the memory acknowledges the write.
    assign w_pop  = (state_q == S_DL_BUSY) && bus.mem_ack;

    // A byte arriving while the FIFO is full still fits if the head leaves
    // on the same edge. Otherwise it is lost and the overrun flag latches.
    assign w_push = bus.dl_wr && (!w_fifo_full || w_pop);
    assign w_drop = bus.dl_wr &&  w_fifo_full && !w_pop;

    assign w_head_addr = fifo_q[rd_ptr_q][32:8];
    assign w_head_data = fifo_q[rd_ptr_q][7:0];

`ifdef DL_CORE_HOLD_EN
    // A core held in reset must not be granted memory.
    assign w_core_block = core_reset_q;
`else
    assign w_core_block = 1'b0;
`endif

    // The core keeps its request high during the cycle that carries its ack.
    // That held level must not be taken as a new request.
    assign w_core_ok    = bus.core_rd_req && !w_core_block && !core_rd_ack_q;
    assign w_core_first = w_core_ok && (starve_q == c_starve_max);

    assign w_grant_dl   = (state_q == S_IDLE) && !w_fifo_empty && !w_core_first;
    assign w_grant_core = (state_q == S_IDLE) && !w_grant_dl && w_core_ok;

    // Next FIFO occupancy from the push/pop pair
    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        case ({w_push, w_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // ------------------------------------------------------------------------
    // FIFO storage. Contents need no reset; validity comes from the pointers.
    // ------------------------------------------------------------------------
    // Write the incoming byte and its address at the tail
    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            fifo_q[wr_ptr_q] <= {bus.dl_addr, bus.dl_data};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            fifo_cnt_q <= 3'd0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Sticky overrun flag: set on any dropped download byte
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_overrun_q <= 1'b0;
        end else if (w_drop) begin
            dl_overrun_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Arbitration FSM with registered memory command and core read response
    // ------------------------------------------------------------------------
    // Grant in IDLE, hold the command until mem_ack, then return to IDLE
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            // A reset while busy abandons the transaction with no ack.
            state_q        <= S_IDLE;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= 24'd0;
            mem_wdata_q    <= 16'd0;
            mem_be_q       <= 2'b00;
            core_rd_ack_q  <= 1'b0;
            core_rd_data_q <= 16'd0;
            starve_q       <= 4'd0;
        end else begin
            core_rd_ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // mem_ack is ignored here; only a grant can leave IDLE.
                    if (w_grant_dl) begin
                        state_q     <= S_DL_BUSY;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= w_head_addr[24:1];
                        mem_wdata_q <= {w_head_data, w_head_data};
                        mem_be_q    <= w_head_addr[0] ? 2'b10 : 2'b01;
                        // Count loader grants that overtake a waiting core.
                        if (bus.core_rd_req && (starve_q != c_starve_max)) begin
                            starve_q <= starve_q + 4'd1;
                        end
                    end else if (w_grant_core) begin
                        state_q     <= S_CORE_BUSY;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.core_rd_addr;
                        mem_wdata_q <= 16'd0;
                        mem_be_q    <= 2'b11;
                        starve_q    <= 4'd0;
                    end
                end
                S_DL_BUSY: begin
                    // The FIFO pop happens on this same edge.
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                S_CORE_BUSY: begin
                    if (bus.mem_ack) begin
                        core_rd_data_q <= bus.mem_rdata;
                        core_rd_ack_q  <= 1'b1;
                        mem_req_q      <= 1'b0;
                        state_q        <= S_IDLE;
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Core reset generation
    // ------------------------------------------------------------------------
`ifdef DL_CORE_HOLD_EN
    logic       w_hold_src;
    logic [4:0] hold_cnt_q;

    assign w_hold_src = reset || bus.dl_active || !w_fifo_empty ||
                        (state_q == S_DL_BUSY);

    // Hold core reset while any download activity remains, then for a tail
    always_ff @(posedge clk_sys) begin
        if (w_hold_src) begin
            hold_cnt_q   <= c_hold_cycles;
            core_reset_q <= 1'b1;
        end else if (hold_cnt_q != 5'd0) begin
            hold_cnt_q   <= hold_cnt_q - 5'd1;
            core_reset_q <= 1'b1;
        end else begin
            core_reset_q <= 1'b0;
        end
    end
`else
    // Core reset is the system reset delayed by one cycle
    always_ff @(posedge clk_sys) begin
        core_reset_q <= reset;
    end
`endif

    // ------------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------------
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.mem_be       = mem_be_q;
    assign bus.core_rd_ack  = core_rd_ack_q;
    assign bus.core_rd_data = core_rd_data_q;
    assign bus.dl_overrun   = dl_overrun_q;
    assign bus.core_reset   = core_reset_q;

endmodule
`default_nettype wire

// File: doc/dl_mem_arbiter.md
DL_MEM_ARBITER -- requirements
Module: dl_mem_arbiter

Interface
REQ-001 SHALL: clk_sys  in  1  sole clock; all logic on its rising edge.
REQ-002 SHALL: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL: dl_active  in  1  ROM download in progress (ioctl_download).
REQ-004 SHALL: dl_wr  in  1  one-cycle download byte strobe, no backpressure.
REQ-005 SHALL: dl_addr  in  25  download byte address.
REQ-006 SHALL: dl_data  in  8  download byte.
REQ-007 SHALL: core_rd_req  in  1  core read request level, held until core_rd_ack.
REQ-008 SHALL: core_rd_addr  in  24  core word address, stable while core_rd_req is high.
REQ-009 SHALL: core_rd_data  out  16  read data, valid with core_rd_ack.
REQ-010 SHALL: core_rd_ack  out  1  one-cycle read completion pulse.
REQ-011 SHALL: mem_req  out  1  memory request level, held until mem_ack.
REQ-012 SHALL: mem_we, mem_addr[23:0], mem_wdata[15:0], mem_be[1:0]  out  memory command fields, stable while mem_req is high.
REQ-013 SHALL: mem_ack  in  1  one-cycle completion; mem_rdata[15:0] in, valid in the same cycle.
REQ-014 SHALL: core_reset  out  1  reset to game core.
REQ-015 SHALL: dl_overrun  out  1  sticky flag, download byte dropped.

Function
REQ-016 SHALL: buffer download bytes in a 4-entry FIFO of {addr, data}; push on dl_wr.
REQ-017 SHALL: on dl_wr with FIFO full and no pop in the same cycle, drop the byte and set dl_overrun; on a simultaneous push and pop while full, accept the byte.
REQ-018 SHALL: run the FSM states IDLE, DL_BUSY and CORE_BUSY; arbitrate only in IDLE.
REQ-019 SHALL: in IDLE, grant the loader when the FIFO is non-empty and the core is not eligible, else grant the core when core_rd_req is high and eligible, else stay in IDLE.
REQ-020 SHALL: make the core eligible ahead of the loader when starve_cnt equals 8; starve_cnt is a 4-bit counter, incremented on each loader grant while core_rd_req is high, cleared on each core grant, saturating at 8.
REQ-021 SHALL: assert mem_req, with its command fields registered, on the edge that enters DL_BUSY or CORE_BUSY, and hold it until mem_ack.
REQ-022 SHALL: encode a loader write as mem_we=1, mem_addr=dl_addr[24:1], mem_wdata={data,data}, mem_be=2'b10 when dl_addr[0]=1 else 2'b01.
REQ-023 SHALL: encode a core read as mem_we=0, mem_addr=core_rd_addr, mem_be=2'b11.
REQ-024 SHALL: on mem_ack in DL_BUSY, pop the FIFO, drop mem_req and return to IDLE on the same edge.
REQ-025 SHALL: on mem_ack in CORE_BUSY, register mem_rdata into core_rd_data, pulse core_rd_ack for one cycle, drop mem_req and return to IDLE.
REQ-026 SHALL: from a core request sampled in IDLE with an empty FIFO, assert mem_req after 1 cycle, and assert core_rd_ack 1 cycle after mem_ack.
REQ-027 SHALL: always leave one IDLE cycle between consecutive grants.
REQ-028 SHALL: ignore mem_ack while in IDLE.
REQ-029 SHALL: hold core_rd_data at its last value between acks.

Reset
REQ-030 SHALL: on reset, set FSM=IDLE, empty the FIFO, and clear mem_req, core_rd_ack, dl_overrun, starve_cnt, core_rd_data and mem_* fields.
REQ-031 SHALL: on reset, set core_reset=1.
REQ-032 SHALL: on reset during DL_BUSY or CORE_BUSY, abandon the transaction, drop mem_req on that edge, and issue no ack; the memory controller tolerates abandoned requests.

Configuration
REQ-033 SHALL: with macro DL_CORE_HOLD_EN defined, drive core_reset=1 while reset, dl_active, a non-empty FIFO or DL_BUSY holds, then keep it high 16 further cycles.
REQ-034 SHALL: with DL_CORE_HOLD_EN defined, make the core ineligible while core_reset=1.
REQ-035 SHALL: without DL_CORE_HOLD_EN, register core_reset from reset only (1-cycle delay) and apply REQ-019/REQ-020 unchanged during download.

Verification
REQ-036 SHALL: bench covers single read: FIFO empty, core_rd_req with addr 0x000123, mem_ack with rdata 0xBEEF -> mem_addr=0x000123 and mem_we=0 one cycle after the request; core_rd_ack with data 0xBEEF one cycle after mem_ack.
REQ-037 SHALL: bench covers byte write: dl_wr with addr 0x0000005 and data 0x5A -> mem_addr=0x000002, mem_be=2'b10, mem_wdata=0x5A5A, FIFO empty after mem_ack.
REQ-038 SHALL: bench covers overrun: 6 dl_wr on consecutive cycles with mem_ack withheld -> 4 bytes stored, dl_overrun=1, 4 writes in order once acks resume.
REQ-039 SHALL: bench covers starvation (DL_CORE_HOLD_EN undefined): FIFO refilled continuously and core_rd_req held -> core granted after exactly 8 loader grants.
REQ-040 SHALL: bench covers hold (DL_CORE_HOLD_EN defined): dl_active falls with the FIFO empty -> core_reset falls 16 cycles later; core_rd_req before then gets no grant.
REQ-041 SHALL: bench covers mid-transaction reset: reset in CORE_BUSY -> mem_req=0 next cycle, no core_rd_ack, FSM=IDLE.
